// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and helpers for the round-robin packet arbiter.
package rr_mux_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Modulo-n increment that stays correct for non-power-of-two n.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate by ptr, priority-encode, un-rotate.
module rr_pick #(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [SW-1:0] ptr_i,
    output logic          found_o,
    output logic [SW-1:0] idx_o
);

    localparam logic [SW:0] N_W = (SW+1)'(N);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;
    logic [SW-1:0]  rot_idx;
    logic [SW:0]    sum;

    // Doubling the vector makes the rotate correct for any N, not just 2^k.
    assign doubled = {req_i, req_i};
    assign rotated = N'(doubled >> ptr_i);

    always_comb begin
        // NOTE: default assigned first so no path through the loop infers a latch.
        rot_idx = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rotated[j]) begin
                rot_idx = SW'(j);
            end
        end
    end

    assign found_o = |req_i;
    assign sum     = {1'b0, rot_idx} + {1'b0, ptr_i};
    assign idx_o   = (sum >= N_W) ? SW'(sum - N_W) : SW'(sum);

endmodule

// File: rtl/rr_mux_arbiter.sv
// Packet-atomic round-robin arbiter driving an N:1 data mux into one registered
// valid/ready output channel.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          in_valid_i,
    input  logic [N-1:0]          in_last_i,
    input  logic [N*W-1:0]        in_data_i,
    output logic [N-1:0]          in_ready_o,
    output logic                  out_valid_o,
    output logic                  out_last_o,
    output logic [W-1:0]          out_data_o,
    output logic [$clog2(N)-1:0]  out_sel_o,
    input  logic                  out_ready_i
);

    localparam int SW = $clog2(N);

    arb_state_t    state_q, state_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic [SW-1:0] owner_q, owner_d;

    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_sel_q, out_sel_d;

    logic          load_en;
    logic          pick_found;
    logic [SW-1:0] pick_idx;
    logic          grant_valid;
    logic [SW-1:0] grant_idx;
    logic          grant_last;
    logic [W-1:0]  grant_data;
    logic          accept;

    rr_pick #(.N(N), .SW(SW)) u_pick (
        .req_i   (in_valid_i),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign load_en    = !out_valid_q || out_ready_i;
    assign grant_last = in_last_i[grant_idx];
    assign grant_data = in_data_i[grant_idx*W +: W];
    assign accept     = grant_valid && load_en && !rst;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
        end
    end

    // Next-state logic; pointer and owner move only on an accepted beat.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        if (accept) begin
            if (grant_last) begin
                state_d = IDLE;
                ptr_d   = SW'(wrap_inc(32'(grant_idx), N));
            end else begin
                state_d = LOCKED;
                owner_d = grant_idx;
            end
        end
    end

    // Output logic: an owner excludes everyone else, even while it bubbles.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        case (state_q)
            IDLE: begin
                grant_valid = pick_found;
                grant_idx   = pick_idx;
            end
            LOCKED: begin
                grant_valid = in_valid_i[owner_q];
                grant_idx   = owner_q;
            end
            default: begin
                grant_valid = 1'b0;
                grant_idx   = '0;
            end
        endcase
        in_ready_o = '0;
        if (accept) begin
            in_ready_o[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (load_en) begin
            out_valid_d = accept;
            if (accept) begin
                out_last_d = grant_last;
                out_data_d = grant_data;
                out_sel_d  = grant_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            owner_q     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign out_data_o  = out_data_q;
    assign out_sel_o   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_rr_mux_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]   in_valid, in_last, in_ready;
    logic [N*W-1:0] in_data;
    logic           out_valid, out_last, out_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;

    logic [2:0]  v3, l3, r3;
    logic [23:0] d3;
    logic        ov3, ol3, ordy3;
    logic [7:0]  od3;
    logic [1:0]  os3;

    rr_mux_arbiter #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid), .in_last_i(in_last), .in_data_i(in_data),
        .in_ready_o(in_ready),
        .out_valid_o(out_valid), .out_last_o(out_last), .out_data_o(out_data),
        .out_sel_o(out_sel), .out_ready_i(out_ready)
    );

    rr_mux_arbiter #(.N(3), .W(8)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid_i(v3), .in_last_i(l3), .in_data_i(d3),
        .in_ready_o(r3),
        .out_valid_o(ov3), .out_last_o(ol3), .out_data_o(od3),
        .out_sel_o(os3), .out_ready_i(ordy3)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Behavioural model of the arbiter, in spec terms.
    bit         m_locked;
    int         m_owner;
    int         m_ptr;
    logic       m_ov, m_ol;
    logic [7:0] m_od;
    int         m_os;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_ptr    = 0;
        m_ov     = 1'b0;
        m_ol     = 1'b0;
        m_od     = '0;
        m_os     = 0;
    endtask

    // Requester accepted this cycle, or -1.
    function automatic int model_pick(input logic [N-1:0] v, input logic ordy);
        if (m_ov && !ordy) return -1;
        if (m_locked) return v[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // One clock: drive, check in_ready, clock, update model, check outputs.
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] l, input logic ordy, input string tag);
        int           g;
        logic [N-1:0] exp_rdy;
        in_valid  = v;
        in_last   = l;
        out_ready = ordy;
        #1;
        g       = model_pick(v, ordy);
        exp_rdy = (g >= 0) ? N'(1 << g) : '0;
        check($sformatf("%s.in_ready", tag), 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (!m_ov || ordy) begin
            m_ov = (g >= 0);
            if (g >= 0) begin
                m_od = in_data[g*W +: W];
                m_ol = l[g];
                m_os = g;
                if (l[g]) begin
                    m_locked = 1'b0;
                    m_ptr    = (g + 1) % N;
                end else begin
                    m_locked = 1'b1;
                    m_owner  = g;
                end
            end
        end
        #1;
        check($sformatf("%s.out_valid", tag), 32'(out_valid), 32'(m_ov));
        check($sformatf("%s.out_data", tag), 32'(out_data), 32'(m_od));
        check($sformatf("%s.out_last", tag), 32'(out_last), 32'(m_ol));
        check($sformatf("%s.out_sel", tag), 32'(out_sel), 32'(m_os));
    endtask

    initial begin
        // Reset with every requester asking: nothing may be granted.
        rst       = 1'b1;
        in_valid  = '1;
        in_last   = '1;
        out_ready = 1'b1;
        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        v3        = '0;
        l3        = '0;
        d3        = {8'hC2, 8'hC1, 8'hC0};
        ordy3     = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset.in_ready", 32'(in_ready), 32'h0);
        check("reset.out_valid", 32'(out_valid), 32'h0);
        check("reset.out_data", 32'(out_data), 32'h0);
        check("reset.out_sel", 32'(out_sel), 32'h0);
        in_valid = '0;
        rst      = 1'b0;
        @(posedge clk);
        #1;

        // Rotation: single-beat packets from everyone -> 0,1,2,3,0.
        step(4'b1111, 4'b1111, 1'b1, "first");
        check("first.sel", 32'(out_sel), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(4'b1111, 4'b1111, 1'b1, "rot");
            check("rot.sel", 32'(out_sel), 32'((i + 1) % 4));
            check("rot.data", 32'(out_data), 32'(8'hA0 + (i + 1) % 4));
        end

        // Packet lock: requester 1 sends three beats while 0 and 2 wait.
        step(4'b0111, 4'b0101, 1'b1, "lock1");
        check("lock1.sel", 32'(out_sel), 32'd1);
        step(4'b0111, 4'b0101, 1'b1, "lock2");
        check("lock2.sel", 32'(out_sel), 32'd1);
        step(4'b0111, 4'b0111, 1'b1, "lock3");
        check("lock3.sel", 32'(out_sel), 32'd1);
        check("lock3.last", 32'(out_last), 32'd1);
        step(4'b0101, 4'b0101, 1'b1, "lock4");
        check("lock4.sel", 32'(out_sel), 32'd2);
        step(4'b0001, 4'b0001, 1'b1, "lock5");
        check("lock5.sel", 32'(out_sel), 32'd0);

        // Backpressure: output holds and nothing is accepted.
        for (int i = 0; i < 3; i++) begin
            step(4'b0010, 4'b0010, 1'b0, "bp");
            check("bp.in_ready0", 32'(in_ready), 32'h0);
            check("bp.data_hold", 32'(out_data), 32'hA0);
            check("bp.valid_hold", 32'(out_valid), 32'd1);
        end
        step(4'b0010, 4'b0010, 1'b1, "bp_rel");
        check("bp_rel.sel", 32'(out_sel), 32'd1);
        check("bp_rel.data", 32'(out_data), 32'hA1);

        // Bubble: owner 3 pauses; requester 0 must not slip in.
        step(4'b1000, 4'b0000, 1'b1, "bub_start");
        check("bub_start.sel", 32'(out_sel), 32'd3);
        for (int i = 0; i < 2; i++) begin
            step(4'b0001, 4'b0001, 1'b1, "bub");
            check("bub.valid", 32'(out_valid), 32'd0);
            check("bub.sel_hold", 32'(out_sel), 32'd3);
        end
        step(4'b1001, 4'b1001, 1'b1, "bub_last");
        check("bub_last.sel", 32'(out_sel), 32'd3);
        step(4'b0001, 4'b0001, 1'b1, "bub_after");
        check("bub_after.sel", 32'(out_sel), 32'd0);

        // Asynchronous reset in the middle of a packet from requester 2.
        step(4'b0100, 4'b0000, 1'b1, "mid_pkt");
        check("mid_pkt.valid", 32'(out_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst.out_valid", 32'(out_valid), 32'h0);
        check("async_rst.out_data", 32'(out_data), 32'h0);
        check("async_rst.out_sel", 32'(out_sel), 32'h0);
        check("async_rst.out_last", 32'(out_last), 32'h0);
        check("async_rst.in_ready", 32'(in_ready), 32'h0);
        model_reset();
        in_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(4'b1111, 4'b1111, 1'b1, "post_rst");
        check("post_rst.sel", 32'(out_sel), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_data = $urandom;
            step(N'($urandom), N'($urandom & $urandom), ($urandom_range(0, 3) != 0), "rand");
        end
        in_valid = '0;

        // Pointer wrap on the non-power-of-two instance.
        v3 = 3'b100;
        l3 = 3'b100;
        #1;
        check("wrap.rdy2", 32'(r3), 32'b100);
        @(posedge clk);
        #1;
        check("wrap.sel2", 32'(os3), 32'd2);
        check("wrap.data2", 32'(od3), 32'hC2);
        v3 = 3'b011;
        l3 = 3'b011;
        #1;
        check("wrap.rdy0", 32'(r3), 32'b001);
        @(posedge clk);
        #1;
        check("wrap.sel0", 32'(os3), 32'd0);
        check("wrap.data0", 32'(od3), 32'hC0);
        check("wrap.valid", 32'(ov3), 32'd1);
        v3 = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
